// File: rtl/mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_iter                                                  |
// | Purpose  : Iterative radix-2 multiply / restoring divide unit with   |
// |            HI/LO result registers, MADD/MSUB accumulate, busy/done   |
// |            handshake and IRQ cancel. One step per cycle, WIDTH       |
// |            cycles per operation.                                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] RSD,
  input  logic [WIDTH-1:0] RTD,
  input  logic [3:0]       CTL,
  input  logic             IRQ,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

  localparam logic [3:0] c_OP_MFLO  = 4'd0;
  localparam logic [3:0] c_OP_MFHI  = 4'd1;
  localparam logic [3:0] c_OP_MTHI  = 4'd2;
  localparam logic [3:0] c_OP_MTLO  = 4'd3;
  localparam logic [3:0] c_OP_MULT  = 4'd4;
  localparam logic [3:0] c_OP_MULTU = 4'd5;
  localparam logic [3:0] c_OP_DIV   = 4'd6;
  localparam logic [3:0] c_OP_DIVU  = 4'd7;
  localparam logic [3:0] c_OP_MADD  = 4'd8;
  localparam logic [3:0] c_OP_MADDU = 4'd9;
  localparam logic [3:0] c_OP_MSUB  = 4'd10;
  localparam logic [3:0] c_OP_MSUBU = 4'd11;

  // Committed architectural state
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  // Working state. For multiplies r_acc is the product accumulator; for
  // divides it holds {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;     // multiplicand / divisor magnitude (raw RSD on divide-by-zero)
  logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right one bit per step
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_op;
  logic               r_neg_q;   // negate product / quotient at commit
  logic               r_neg_r;   // negate remainder at commit
  logic               r_dz;      // divide by zero: result fixed at accept
  logic               r_busy;
  logic               r_done;

  // Operand conditioning at accept: signed opcodes work on magnitudes.
  // The magnitude of the most negative value is its own unsigned pattern,
  // which is what makes DIV -2^(W-1) / -1 fall out as -2^(W-1) rem 0.
  logic             w_ctl_signed;
  logic             w_rsd_neg;
  logic             w_rtd_neg;
  logic [WIDTH-1:0] w_rsd_mag;
  logic [WIDTH-1:0] w_rtd_mag;

  assign w_ctl_signed = (CTL == c_OP_MULT) || (CTL == c_OP_DIV) ||
                        (CTL == c_OP_MADD) || (CTL == c_OP_MSUB);
  assign w_rsd_neg    = w_ctl_signed & RSD[WIDTH-1];
  assign w_rtd_neg    = w_ctl_signed & RTD[WIDTH-1];
  assign w_rsd_mag    = w_rsd_neg ? -RSD : RSD;
  assign w_rtd_mag    = w_rtd_neg ? -RTD : RTD;

  // One shift-add multiply step: add multiplicand into the upper half,
  // then shift the whole accumulator right with the carry.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_mplier[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift {rem,quo} left, trial-subtract the
  // divisor from the widened remainder, keep it if no borrow.
  logic [WIDTH:0]     w_div_hi;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_hi   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_hi - {1'b0, r_opb};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_hi[WIDTH-1:0];
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  logic               w_op_div;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_op_div   = (r_op == c_OP_DIV) || (r_op == c_OP_DIVU);
  assign w_acc_next = w_op_div ? w_div_next : w_mul_next;

  // Commit values: the final step result with signs applied, accumulated
  // onto the current HI/LO for MADD/MSUB.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_commit_hi;
  logic [WIDTH-1:0]   w_commit_lo;

  assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_hilo = {r_hi, r_lo};
  assign w_quo  = w_acc_next[WIDTH-1:0];
  assign w_rem  = w_acc_next[2*WIDTH-1:WIDTH];

  // Select the multiply result flavour and the final HI/LO write data
  always_comb begin
    w_mul_res = w_prod;
    if ((r_op == c_OP_MADD) || (r_op == c_OP_MADDU)) begin
      w_mul_res = w_hilo + w_prod;
    end else if ((r_op == c_OP_MSUB) || (r_op == c_OP_MSUBU)) begin
      w_mul_res = w_hilo - w_prod;
    end
    w_commit_hi = w_mul_res[2*WIDTH-1:WIDTH];
    w_commit_lo = w_mul_res[WIDTH-1:0];
    if (w_op_div) begin
      if (r_dz) begin
        w_commit_lo = {WIDTH{1'b1}};
        w_commit_hi = r_opb;
      end else begin
        w_commit_lo = r_neg_q ? -w_quo : w_quo;
        w_commit_hi = r_neg_r ? -w_rem : w_rem;
      end
    end
  end

  // Accept, iterate, commit or cancel; HI/LO only change on MT* or commit
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (IRQ) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - c_CNT_LAST;
          if (r_cnt == c_CNT_LAST) begin
            r_hi   <= w_commit_hi;
            r_lo   <= w_commit_lo;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end else if (!IRQ) begin
        case (CTL)
          c_OP_MTHI: r_hi <= RSD;
          c_OP_MTLO: r_lo <= RSD;
          c_OP_MULT, c_OP_MULTU, c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: begin
            r_op     <= CTL;
            r_acc    <= '0;
            r_opb    <= w_rsd_mag;
            r_mplier <= w_rtd_mag;
            r_neg_q  <= w_rsd_neg ^ w_rtd_neg;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= c_CNT_INIT;
            r_busy   <= 1'b1;
          end
          c_OP_DIV, c_OP_DIVU: begin
            r_op     <= CTL;
            r_acc    <= {{WIDTH{1'b0}}, w_rsd_mag};
            r_opb    <= (RTD == '0) ? RSD : w_rtd_mag;
            r_mplier <= '0;
            r_neg_q  <= w_rsd_neg ^ w_rtd_neg;
            r_neg_r  <= w_rsd_neg;
            r_dz     <= (RTD == '0);
            r_cnt    <= c_CNT_INIT;
            r_busy   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Read port always shows the committed HI/LO
  always_comb begin
    out = '0;
    if (CTL == c_OP_MFLO) begin
      out = r_lo;
    end else if (CTL == c_OP_MFHI) begin
      out = r_hi;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire
